key_event: RTL and testbench

- Consumes the debounced, clean key level produced by the key debouncer stage.
- Classifies the key level into one-cycle event pulses: short press, long press, auto-repeat while held, and double click.
- Feeds the camera control logic (mode/menu/exposure stepping), so each downstream handler sees exactly one pulse per user action.

---
 rtl/key_event.sv | 150 +++++++++++++++
 tb/tb_key_event.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// Key event classifier: turns a debounced key level into one-cycle short press,
// long press, auto-repeat and double-click pulses for the camera control logic.
module key_event #(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned DBL_TICKS    = 250,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned TW           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click
);

  localparam int unsigned   PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TICKS - 1);
  localparam logic [TW-1:0] DBL_LAST    = TW'(DBL_TICKS - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pressed_q;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          double_q, double_d;

  logic k;
  logic press_edge;
  logic release_edge;
  logic tick;
  logic long_exp;
  logic dbl_exp;
  logic repeat_exp;
  logic restart;

  // Polarity-normalised level; edges are taken against the registered level.
  assign k            = key_in ^ ACTIVE_LOW;
  assign press_edge   = k & ~pressed_q;
  assign release_edge = ~k & pressed_q;

  assign tick       = (presc_q == PRESC_LAST);
  assign long_exp   = tick && (timer_q == LONG_LAST);
  assign dbl_exp    = tick && (timer_q == DBL_LAST);
  assign repeat_exp = tick && (timer_q == REPEAT_LAST);

  // Next-state and pulse decode; edges take priority over same-cycle expiry.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    double_d = 1'b0;
    restart  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_edge) state_d = PRESS1;
      end
      PRESS1: begin
        if (release_edge) begin
          state_d = WAIT2;
        end else if (long_exp) begin
          state_d = HOLD;
          long_d  = 1'b1;
        end
      end
      HOLD: begin
        if (release_edge) begin
          state_d = IDLE;
        end else if (repeat_exp) begin
          repeat_d = 1'b1;
          restart  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_edge) begin
          state_d = PRESS2;
        end else if (dbl_exp) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (release_edge) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timebase restarts on every state change and on each repeat; timer saturates.
  always_comb begin
    presc_d = presc_q;
    timer_d = timer_q;
    if ((state_d != state_q) || restart) begin
      presc_d = '0;
      timer_d = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick && (timer_q != '1)) timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      timer_q   <= '0;
      pressed_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      double_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      pressed_q <= k;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      double_q  <= double_d;
    end
  end

  assign pressed      = pressed_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign repeat_pulse = repeat_q;
  assign double_click = double_q;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: table of click patterns with expected pulse counts, timed
// corner sequences, and random key traffic checked cycle-by-cycle against a model.
module tb_key_event;

  localparam int unsigned TD = 4;
  localparam int unsigned LT = 10;
  localparam int unsigned DT = 5;
  localparam int unsigned RT = 3;

  localparam int P_IDLE = 0, P_PRESS1 = 1, P_HOLD = 2, P_WAIT2 = 3, P_PRESS2 = 4;
  localparam int B_SHORT = 3, B_LONG = 2, B_REP = 1, B_DBL = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic pressed, short_press, long_press, repeat_pulse, double_click;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_event #(
    .ACTIVE_LOW  (1'b1),
    .TICK_DIV    (TD),
    .LONG_TICKS  (LT),
    .DBL_TICKS   (DT),
    .REPEAT_TICKS(RT),
    .TW          (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .pressed     (pressed),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .double_click(double_click)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: phase plus cycles-since-entry; an N-tick window closes at age N*TD-1.
  int         m_phase, m_age, m_next;
  logic       m_pressed, m_k, m_pe, m_re, m_restart;
  logic [3:0] m_out, m_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   = P_IDLE;
      m_age     = 0;
      m_pressed = 1'b0;
      m_out     = 4'b0;
    end else begin
      m_k       = ~key_in;
      m_pe      = m_k & ~m_pressed;
      m_re      = ~m_k & m_pressed;
      m_next    = m_phase;
      m_o       = 4'b0;
      m_restart = 1'b0;
      case (m_phase)
        P_IDLE:   if (m_pe) m_next = P_PRESS1;
        P_PRESS1: if (m_re) m_next = P_WAIT2;
                  else if (m_age == int'(LT * TD) - 1) begin m_next = P_HOLD; m_o[B_LONG] = 1'b1; end
        P_HOLD:   if (m_re) m_next = P_IDLE;
                  else if (m_age == int'(RT * TD) - 1) begin m_o[B_REP] = 1'b1; m_restart = 1'b1; end
        P_WAIT2:  if (m_pe) m_next = P_PRESS2;
                  else if (m_age == int'(DT * TD) - 1) begin m_next = P_IDLE; m_o[B_SHORT] = 1'b1; end
        default:  if (m_re) begin m_next = P_IDLE; m_o[B_DBL] = 1'b1; end
      endcase
      m_age     = (m_next != m_phase || m_restart) ? 0 : ((m_age < 1000000) ? m_age + 1 : m_age);
      m_phase   = m_next;
      m_pressed = m_k;
      m_out     = m_o;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pressed", int'(pressed), int'(m_pressed));
      check("model_pulses", int'({short_press, long_press, repeat_pulse, double_click}), int'(m_out));
      check("onehot0", int'($onehot0({short_press, long_press, repeat_pulse, double_click})), 1);
    end
  end

  logic [3:0] seen;
  int n_short, n_long, n_rep, n_dbl;

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_rep = 0; n_dbl = 0;
  endtask

  // One cycle: sample outputs at the falling edge, then drive the next key level.
  task automatic step(input logic key);
    @(negedge clk);
    seen = {short_press, long_press, repeat_pulse, double_click};
    n_short += int'(short_press);
    n_long  += int'(long_press);
    n_rep   += int'(repeat_pulse);
    n_dbl   += int'(double_click);
    key_in = key;
  endtask

  task automatic hold(input logic key, input int n);
    repeat (n) step(key);
  endtask

  task automatic run_until(input int sel, input logic key, input int max_n, output int n);
    n = -1;
    for (int i = 1; i <= max_n; i++) begin
      step(key);
      if (seen[sel]) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    string name;
    int    low1, high1, low2;
    int    e_short, e_long, e_rep, e_dbl;
  } vec_t;

  vec_t tbl[9];
  int   n;
  int   len;
  logic lvl;
  int   picks[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{"short_click",    8,  0,   0, 1, 0, 0, 0};
    tbl[1] = '{"long_hold",     80,  0,   0, 0, 1, 3, 0};
    tbl[2] = '{"double_click",   6,  8,   6, 0, 0, 0, 1};
    tbl[3] = '{"release_at_exp",40,  0,   0, 1, 0, 0, 0};
    tbl[4] = '{"release_after", 41,  0,   0, 0, 1, 0, 0};
    tbl[5] = '{"press_at_dbl",   6, 20,   6, 0, 0, 0, 1};
    tbl[6] = '{"press_past_dbl", 6, 21,   6, 2, 0, 0, 0};
    tbl[7] = '{"one_repeat",    53,  0,   0, 0, 1, 1, 0};
    tbl[8] = '{"press2_long",    6,  8, 100, 0, 0, 0, 1};
    picks  = '{12, 13, 20, 21, 40, 41};

    rst_n  = 1'b0;
    key_in = 1'b1;
    clear_counts();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset with the key toggling.
    for (int i = 0; i < 4; i++) step(logic'(i % 2));
    check("reset_outs", int'({pressed, short_press, long_press, repeat_pulse, double_click}), 0);
    step(1'b1);
    #2 rst_n = 1'b1;
    clear_counts();
    hold(1'b1, 100);
    check("idle_pulses", n_short + n_long + n_rep + n_dbl, 0);
    check("idle_pressed", int'(pressed), 0);

    // Short click: pulse 20 cycles after the release edge.
    hold(1'b0, 8);
    run_until(B_SHORT, 1'b1, 60, n);
    check("short_latency", n, int'(DT * TD) + 2);
    hold(1'b1, 30);

    // Long hold: long 40 cycles after the press edge, then repeats every 12.
    run_until(B_LONG, 1'b0, 80, n);
    check("long_latency", n, int'(LT * TD) + 2);
    check("long_pressed", int'(pressed), 1);
    run_until(B_REP, 1'b0, 40, n);
    check("repeat1_gap", n, int'(RT * TD));
    run_until(B_REP, 1'b0, 40, n);
    check("repeat2_gap", n, int'(RT * TD));
    clear_counts();
    hold(1'b1, 40);
    check("hold_no_short", n_short, 0);

    // Double click: pulse right after the second release edge.
    hold(1'b0, 6); hold(1'b1, 8); hold(1'b0, 6);
    run_until(B_DBL, 1'b1, 10, n);
    check("dbl_latency", n, 2);
    hold(1'b1, 30);

    for (int v = 0; v < 9; v++) begin
      clear_counts();
      hold(1'b0, tbl[v].low1);
      if (tbl[v].high1 > 0) hold(1'b1, tbl[v].high1);
      if (tbl[v].low2 > 0) hold(1'b0, tbl[v].low2);
      hold(1'b1, 40);
      check({tbl[v].name, "_short"}, n_short, tbl[v].e_short);
      check({tbl[v].name, "_long"},  n_long,  tbl[v].e_long);
      check({tbl[v].name, "_rep"},   n_rep,   tbl[v].e_rep);
      check({tbl[v].name, "_dbl"},   n_dbl,   tbl[v].e_dbl);
    end

    // Reset during HOLD drops the pending sequence.
    hold(1'b0, 45);
    #2 rst_n = 1'b0;
    hold(1'b0, 3);
    check("rst_hold_outs", int'({pressed, short_press, long_press, repeat_pulse, double_click}), 0);
    step(1'b1);
    #2 rst_n = 1'b1;
    clear_counts();
    hold(1'b1, 60);
    check("rst_hold_after", n_short + n_long + n_rep + n_dbl, 0);

    // Reset during WAIT2 cancels the pending short press.
    hold(1'b0, 6); hold(1'b1, 5);
    #2 rst_n = 1'b0;
    hold(1'b1, 3);
    #2 rst_n = 1'b1;
    clear_counts();
    hold(1'b1, 40);
    check("rst_wait2_short", n_short, 0);

    // Key held through reset counts as a fresh press.
    #2 rst_n = 1'b0;
    hold(1'b0, 3);
    #2 rst_n = 1'b1;
    clear_counts();
    run_until(B_LONG, 1'b0, 80, n);
    check("held_rst_long", n, int'(LT * TD) + 1);
    check("held_rst_nopulse", n_short + n_rep + n_dbl, 0);
    hold(1'b1, 40);

    // Random key traffic with occasional resets, biased toward window boundaries.
    lvl = 1'b1;
    for (int s = 0; s < 150; s++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : int'($urandom_range(1, 70));
      hold(lvl, len);
      if ($urandom_range(0, 24) == 0) begin
        #2 rst_n = 1'b0;
        step(lvl);
        #2 rst_n = 1'b1;
      end
    end
    hold(1'b1, 40);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
